mux_4x1_rr_arbiter: RTL

- Round-robin arbiter that shares one 4:1 bit mux among four requesters.
- Generates the registered 2-bit mux select and a one-hot grant.
- Registers the selected data bit with a valid flag.
- Sits in front of the 4:1 mux datapath. Each requester drives one lane of in[3:0] plus a request line.

---
 rtl/mux_4x1_rr_arbiter.sv | 80 ++++++++
 1 files changed

// File: rtl/mux_4x1_rr_arbiter.sv
// mux_4x1_rr_arbiter: round-robin owner of a shared 4:1 bit mux; define MUX_ARB_LOCK_EN to add the lock input
module mux_4x1_rr_arbiter #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] in,
`ifdef MUX_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic [1:0] s,
  output logic       out,
  output logic       out_valid,
  output logic       busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [4:0] HMAX = 5'(HOLD_CYCLES - 1);
  state_t     state_q;
  logic [3:0] gnt_q;
  logic [1:0] s_q, last_q, pri, idx, win;
  logic [4:0] hold_q;
  logic       out_q, ov_q, win_any, keep, rel, own_req;
  assign own_req = req[s_q];
`ifdef MUX_ARB_LOCK_EN
  assign keep = lock && own_req;
`else
  assign keep = 1'b0;
`endif
  assign rel = !own_req || (hold_q == HMAX && !keep);
  // search from the lane after the previous owner; later (higher-priority) hits overwrite earlier ones
  always_comb begin
    pri = (state_q == GRANT) ? s_q : last_q;
    idx = 2'd0;
    win = 2'd0;
    win_any = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      idx = pri + 2'(k);
      if (req[idx]) begin
        win = idx;
        win_any = 1'b1;
      end
    end
  end
  // grant FSM plus registered data lane; a release re-arbitrates on the same edge so there is no idle gap
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      s_q     <= 2'b00;
      last_q  <= 2'b11;
      hold_q  <= 5'd0;
      out_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      ov_q <= (state_q == GRANT) && own_req;
      if (state_q == GRANT && own_req) out_q <= in[s_q];
      if (state_q == IDLE || rel) begin
        if (state_q == GRANT) last_q <= s_q;
        if (win_any) begin
          state_q <= GRANT;
          gnt_q   <= 4'b0001 << win;
          s_q     <= win;
          hold_q  <= 5'd0;
        end else begin
          state_q <= IDLE;
          gnt_q   <= 4'b0000;
        end
      end else begin
        hold_q <= (hold_q == HMAX) ? hold_q : hold_q + 5'd1;
      end
    end
  end
  assign gnt       = gnt_q;
  assign s         = s_q;
  assign out       = out_q;
  assign out_valid = ov_q;
  assign busy      = (state_q == GRANT);
endmodule
